// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the MEM/WB write-back path and the
// register file.
package pipe_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     word_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on accepted issue,
// cleared on write-back, plus the RAW hazard compare for the two ID sources.
module wb_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
    parameter int NUM_REGS       = 2 ** REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      wb_wen,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic                      rs1_byp,
    input  logic                      rs2_byp,
    output logic                      hazard,
    output logic [NUM_REGS-1:0]       busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                issue_accept;

    // A forwarded source is already satisfied, so its busy bit is masked.
    assign hazard = issue_valid &&
                    ((busy_q[rs1_addr] && !rs1_byp) ||
                     (busy_q[rs2_addr] && !rs2_byp));

    assign issue_accept = issue_valid && !hazard && enable;

    // Clear is applied before set so a newer writer of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (enable && wb_wen) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue_accept && issue_wen) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with pending-write scoreboard at the MEM/WB end.
// Define WB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module wb_regfile_scoreboard
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
    parameter int NUM_REGS       = 2 ** REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      wb_wen,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      hazard,
    output logic [NUM_REGS-1:0]       busy_vec
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;
    logic                                wb_fire;
    logic                                rs1_byp;
    logic                                rs2_byp;

    assign wb_fire = enable && wb_wen;

    // No hardwired zero register: every entry is writable.
    always_comb begin
        regs_d = regs_q;
        if (wb_fire) begin
            regs_d[wb_addr] = wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_byp = wb_fire && (wb_addr == rs1_addr);
    assign rs2_byp = wb_fire && (wb_addr == rs2_addr);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    assign rs1_data = rs1_byp ? wb_wdata : regs_q[rs1_addr];
    assign rs2_data = rs2_byp ? wb_wdata : regs_q[rs2_addr];

    wb_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .wb_wen      (wb_wen),
        .wb_addr     (wb_addr),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_byp     (rs1_byp),
        .rs2_byp     (rs2_byp),
        .hazard      (hazard),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard; expectations follow WB_BYPASS_EN
// when the macro is defined for the build.
module tb_wb_regfile_scoreboard;

    localparam int W = 32;

    localparam int SEL_RS1  = 0;
    localparam int SEL_RS2  = 1;
    localparam int SEL_HAZ  = 2;
    localparam int SEL_BUSY = 3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        wb_wen;
    logic [3:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic        issue_wen;
    logic [3:0]  issue_rd;
    logic        hazard;
    logic [15:0] busy_vec;

    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        name_q[$];
    event         sample_ev;
    int           n_checks;
    int           n_errors;

    wb_regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .wb_wen      (wb_wen),
        .wb_addr     (wb_addr),
        .wb_wdata    (wb_wdata),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .hazard      (hazard),
        .busy_vec    (busy_vec)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic drive_idle();
        enable      = 1'b1;
        wb_wen      = 1'b0;
        wb_addr     = '0;
        wb_wdata    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic expect_out(input int sel, input logic [W-1:0] val, input string name);
        exp_q.push_back(val);
        sel_q.push_back(sel);
        name_q.push_back(name);
    endtask

    task automatic sample();
        #2;
        -> sample_ev;
        #0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        wb_wen   = 1'b1;
        wb_addr  = a;
        wb_wdata = d;
    endtask

    task automatic issue(input logic [3:0] s1, input logic [3:0] s2,
                         input logic wen, input logic [3:0] rd);
        issue_valid = 1'b1;
        rs1_addr    = s1;
        rs2_addr    = s2;
        issue_wen   = wen;
        issue_rd    = rd;
    endtask

    // Scoreboard monitor: drains the expected queue each time outputs are presented.
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        int           sel;
        string        nm;
        forever begin
            @(sample_ev);
            while (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                sel   = sel_q.pop_front();
                nm    = name_q.pop_front();
                case (sel)
                    SEL_RS1:  act_v = rs1_data;
                    SEL_RS2:  act_v = rs2_data;
                    SEL_HAZ:  act_v = {31'b0, hazard};
                    default:  act_v = {16'b0, busy_vec};
                endcase
                n_checks++;
                if (act_v !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        next_cycle();
        issue(4'd0, 4'd15, 1'b0, 4'd0);
        expect_out(SEL_BUSY, 32'h0, "reset_busy");
        expect_out(SEL_HAZ,  32'h0, "reset_hazard");
        expect_out(SEL_RS1,  32'h0, "reset_rs1");
        expect_out(SEL_RS2,  32'h0, "reset_rs2");
        sample();

        // Write and read back, including reg 0 and reg 15
        next_cycle();
        write_reg(4'd3, 32'hDEADBEEF);
        next_cycle();
        rs1_addr = 4'd3;
        expect_out(SEL_RS1, 32'hDEADBEEF, "wr_read_r3");
        write_reg(4'd0, 32'hA5A5A5A5);
        sample();
        next_cycle();
        write_reg(4'd15, 32'h0F0F0F0F);
        rs2_addr = 4'd0;
        expect_out(SEL_RS2, 32'hA5A5A5A5, "wr_read_r0");
        sample();
        next_cycle();
        rs1_addr = 4'd15;
        expect_out(SEL_RS1, 32'h0F0F0F0F, "wr_read_r15");
        sample();

        // enable low blocks the write
        next_cycle();
        enable = 1'b0;
        write_reg(4'd3, 32'h11111111);
        next_cycle();
        rs1_addr = 4'd3;
        expect_out(SEL_RS1, 32'hDEADBEEF, "en_low_no_write");
        sample();

        // RAW on reg 5
        next_cycle();
        issue(4'd0, 4'd0, 1'b1, 4'd5);
        expect_out(SEL_HAZ, 32'h0, "issue_rd5_hazard");
        sample();
        next_cycle();
        issue(4'd0, 4'd5, 1'b0, 4'd0);
        expect_out(SEL_HAZ,  32'h1, "raw_hazard");
        expect_out(SEL_BUSY, 32'h0020, "busy_r5");
        sample();
        next_cycle();
        issue(4'd0, 4'd5, 1'b0, 4'd0);
        write_reg(4'd5, 32'h12);
`ifdef WB_BYPASS_EN
        expect_out(SEL_HAZ, 32'h0,  "wb_cycle_hazard");
        expect_out(SEL_RS2, 32'h12, "wb_cycle_rs2");
`else
        expect_out(SEL_HAZ, 32'h1,  "wb_cycle_hazard");
        expect_out(SEL_RS2, 32'h0,  "wb_cycle_rs2");
`endif
        sample();
        next_cycle();
        issue(4'd0, 4'd5, 1'b0, 4'd0);
        expect_out(SEL_HAZ,  32'h0,  "post_wb_hazard");
        expect_out(SEL_RS2,  32'h12, "post_wb_rs2");
        expect_out(SEL_BUSY, 32'h0,  "post_wb_busy");
        sample();

        // Same register set and cleared together: set wins
        next_cycle();
        issue(4'd0, 4'd0, 1'b1, 4'd7);
        next_cycle();
        expect_out(SEL_BUSY, 32'h0080, "busy_r7");
        issue(4'd0, 4'd0, 1'b1, 4'd7);
        write_reg(4'd7, 32'h77);
        expect_out(SEL_HAZ, 32'h0, "set_clr_same_hazard");
        sample();
        next_cycle();
        rs1_addr = 4'd7;
        expect_out(SEL_BUSY, 32'h0080, "set_wins");
        expect_out(SEL_RS1,  32'h77,   "r7_data");
        sample();

        // Different registers set and cleared together
        next_cycle();
        issue(4'd0, 4'd0, 1'b1, 4'd9);
        next_cycle();
        expect_out(SEL_BUSY, 32'h0280, "busy_r7_r9");
        issue(4'd0, 4'd0, 1'b1, 4'd2);
        write_reg(4'd9, 32'h99);
        sample();
        next_cycle();
        expect_out(SEL_BUSY, 32'h0084, "set2_clr9");
        sample();

        // Rejected issue changes nothing
        next_cycle();
        issue(4'd7, 4'd0, 1'b1, 4'd4);
        expect_out(SEL_HAZ, 32'h1, "reject_hazard");
        sample();
        next_cycle();
        expect_out(SEL_BUSY, 32'h0084, "reject_no_set");
        sample();

        // enable low: hazard still live, no busy update
        next_cycle();
        enable = 1'b0;
        issue(4'd2, 4'd0, 1'b1, 4'd3);
        expect_out(SEL_HAZ, 32'h1, "en_low_hazard");
        sample();
        next_cycle();
        enable = 1'b0;
        issue(4'd0, 4'd0, 1'b1, 4'd3);
        write_reg(4'd2, 32'h22);
        expect_out(SEL_HAZ, 32'h0, "en_low_no_hazard");
        sample();
        next_cycle();
        rs1_addr = 4'd2;
        expect_out(SEL_BUSY, 32'h0084, "en_low_hold_busy");
        expect_out(SEL_RS1,  32'h0,    "en_low_hold_r2");
        sample();

        // Asynchronous reset mid-run
        @(negedge clk);
        drive_idle();
        #1;
        reset = 1'b1;
        issue(4'd7, 4'd2, 1'b0, 4'd0);
        expect_out(SEL_BUSY, 32'h0, "async_rst_busy");
        expect_out(SEL_HAZ,  32'h0, "async_rst_hazard");
        sample();
        for (int i = 0; i < 16; i++) begin
            rs1_addr = 4'(i);
            expect_out(SEL_RS1, 32'h0, $sformatf("rst_r%0d", i));
            sample();
        end
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        issue(4'd7, 4'd2, 1'b0, 4'd0);
        expect_out(SEL_HAZ,  32'h0, "post_rst_hazard");
        expect_out(SEL_BUSY, 32'h0, "post_rst_busy");
        sample();

        next_cycle();
        #1;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
